// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue; the zero_seen flag exists only
// when FQ_ZERO_DROP_EN is defined.
interface fetch_queue_if #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush;
    logic            in_valid1;
    logic            in_valid2;
    logic [XLEN-1:0] in_inst1;
    logic [XLEN-1:0] in_inst2;
    logic [XLEN-1:0] in_pc1;
    logic [XLEN-1:0] in_pc2;
    logic            in_ready;
    logic            out_valid1;
    logic            out_valid2;
    logic [XLEN-1:0] out_inst1;
    logic [XLEN-1:0] out_inst2;
    logic [XLEN-1:0] out_pc1;
    logic [XLEN-1:0] out_pc2;
    logic            dec_ready;
    logic [CW-1:0]   count;
`ifdef FQ_ZERO_DROP_EN
    logic            zero_seen;
`endif

    modport master (
        output flush, in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2, dec_ready,
        input  in_ready, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2, count
`ifdef FQ_ZERO_DROP_EN
        , input zero_seen
`endif
    );

    modport slave (
        input  flush, in_valid1, in_valid2, in_inst1, in_inst2, in_pc1, in_pc2, dec_ready,
        output in_ready, out_valid1, out_valid2, out_inst1, out_inst2, out_pc1, out_pc2, count
`ifdef FQ_ZERO_DROP_EN
        , output zero_seen
`endif
    );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue show-ahead instruction buffer between fetch and decode.
// Optional macro FQ_ZERO_DROP_EN drops all-zero instruction words at enqueue.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic        clk,
    input  logic        rst,
    fetch_queue_if.slave fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] instMem [DEPTH];
    logic [XLEN-1:0] pcMem   [DEPTH];

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   occupancy;

    logic            inReady;
    logic            accept;
    logic            keep1;
    logic            keep2;
    logic            outValid1;
    logic            outValid2;
    logic [CW-1:0]   enqN;
    logic [CW-1:0]   deqN;
    logic [XLEN-1:0] firstInst;
    logic [XLEN-1:0] firstPc;
    logic [PW-1:0]   headPlus1;
    logic [PW-1:0]   tailPlus1;

    // Enqueue/dequeue amounts; a flush cancels both so pointers simply reset.
    always_comb begin
        keep1     = fq.in_valid1;
        keep2     = fq.in_valid2;
`ifdef FQ_ZERO_DROP_EN
        keep1     = fq.in_valid1 && (fq.in_inst1 != '0);
        keep2     = fq.in_valid2 && (fq.in_inst2 != '0);
`endif
        inReady   = (occupancy <= CW'(DEPTH - 2));
        accept    = inReady && !fq.flush;
        enqN      = accept ? (CW'(keep1) + CW'(keep2)) : '0;
        outValid1 = (occupancy >= CW'(1));
        outValid2 = (occupancy >= CW'(2));
        deqN      = (fq.dec_ready && !fq.flush) ? (CW'(outValid1) + CW'(outValid2)) : '0;
        firstInst = keep1 ? fq.in_inst1 : fq.in_inst2;
        firstPc   = keep1 ? fq.in_pc1   : fq.in_pc2;
        headPlus1 = head + PW'(1);
        tailPlus1 = tail + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || fq.flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + PW'(deqN);
            tail      <= tail + PW'(enqN);
            occupancy <= occupancy + enqN - deqN;
        end
    end

    // The surviving older word always lands at tail; slot 2 follows only if both survive.
    always_ff @(posedge clk) begin
        if (!rst && accept && (keep1 || keep2)) begin
            instMem[tail] <= firstInst;
            pcMem[tail]   <= firstPc;
        end
        if (!rst && accept && keep1 && keep2) begin
            instMem[tailPlus1] <= fq.in_inst2;
            pcMem[tailPlus1]   <= fq.in_pc2;
        end
    end

`ifdef FQ_ZERO_DROP_EN
    logic zeroSeen;

    always_ff @(posedge clk) begin
        if (rst || fq.flush) begin
            zeroSeen <= 1'b0;
        end else if (accept && ((fq.in_valid1 && fq.in_inst1 == '0) ||
                                (fq.in_valid2 && fq.in_inst2 == '0))) begin
            zeroSeen <= 1'b1;
        end
    end

    assign fq.zero_seen = zeroSeen;
`endif

    assign fq.in_ready   = inReady;
    assign fq.count      = occupancy;
    assign fq.out_valid1 = outValid1;
    assign fq.out_valid2 = outValid2;
    assign fq.out_inst1  = outValid1 ? instMem[head]      : '0;
    assign fq.out_pc1    = outValid1 ? pcMem[head]        : '0;
    assign fq.out_inst2  = outValid2 ? instMem[headPlus1] : '0;
    assign fq.out_pc2    = outValid2 ? pcMem[headPlus1]   : '0;
endmodule
